fp_mul_seq: RTL and testbench
=============================

# fp_mul_seq

Parametrised multi-cycle IEEE-754-style floating-point multiplier. It is the next generation of the single-format multiplier control path: a full controller plus datapath with generic exponent and mantissa widths and a selectable rounding mode. It has valid/ready handshakes on both sides, a special-case bypass, and exception flags. It sits between the operand register stage and the result writeback in the FP unit.

## Interface
- EXP_W, 8, exponent width (≥3)
- MAN_W, 23, stored fraction width (≥2); P = MAN_W+1 significand bits; BIAS = 2^(EXP_W-1)-1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a, b  in  EXP_W+MAN_W+1  operands {sign, exp, frac}
- rnd_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  EXP_W+MAN_W+1  product
- flags  out  4  {invalid, overflow, underflow, inexact}
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE → UNPACK → MULT → NORM → ROUND → DONE → IDLE. Special operands go UNPACK → DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b and rnd_mode, then go to UNPACK.
- UNPACK:
  - Inputs with exp=0 are flushed to zero (FTZ).
  - sign = sa^sb.
  - Special cases, result to DONE:
    - Either operand NaN, or inf×0: canonical NaN {0, all-ones exp, 1, 0…0}. invalid is set only for inf×0 and for a NaN input whose fraction MSB is 0.
    - Inf × nonzero: ±inf.
    - Zero × finite: ±0.
  - Otherwise, compute exponent = ea+eb−BIAS in EXP_W+2 signed bits, and load the multiplier with {1,fa} and {1,fb}.
- MULT:
  - Shift-add runs one bit per cycle for exactly P cycles and yields a 2P-bit product.
- NORM:
  - If product[2P-1]=1, shift right by 1 and increment the exponent.
  - Extract the MAN_W fraction bits, the guard bit, and sticky = OR of the remaining bits.
- ROUND:
  - RNE: increment the fraction if guard & (sticky | lsb).
  - RTZ: truncate.
  - A fraction carry-out increments the exponent.
  - inexact = guard | sticky.
  - Exponent ≥ 2^EXP_W−1 → overflow and inexact. The result is ±inf under RNE and ±max-finite under RTZ.
  - Exponent ≤ 0 → ±0 with underflow and inexact (FTZ output).
- DONE:
  - out_valid=1, with result and flags held stable until out_ready.
  - On out_ready, go to IDLE. No operand is accepted in that same cycle.

## Timing
- Accept at edge k (in_valid & in_ready).
- Normal path: out_valid rises after edge k+P+4 (1 UNPACK + P MULT + 1 NORM + 1 ROUND + 1). This is 28 cycles for the default format.
- Special path: out_valid rises after edge k+2.
- in_ready is 0 from k+1 until the cycle after the out_valid & out_ready edge.
- There is no overlap of operations and no combinational path from in_valid to in_ready.
- Backpressure: result and flags are unchanged while out_valid & !out_ready, for any number of cycles.
- Reset values (asynchronous, also when asserted mid-operation): state IDLE, in_ready 1, out_valid 0, busy 0, result 0, flags 0, multiplier cleared.
- In-flight data is discarded. The first accept is possible on the first edge after reset deassertion.
- rnd_mode, a and b changing after accept have no effect.

## Structure
- Package fp_mul_pkg:
  - state enum
  - RND_RNE/RND_RTZ constants
  - flag bit indices (FLG_INVALID=3, FLG_OVF=2, FLG_UDF=1, FLG_INX=0)
  - canonical-NaN and max-finite functions parametrised by EXP_W/MAN_W
- One sub-module, fp_mul_shift_add:
  - P-bit iterative unsigned multiplier
  - interface: start, done, and a 2P-bit product
  - step counter internal to the sub-module
- The top level holds the FSM, unpack, normalise and round logic.

## Test plan
- Basic product: 0x3FC00000 × 0x40000000 (1.5×2), RNE → 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
- Special bypass:
  - 0x7F800000 × 0x00000000 → 0x7FC00000 with invalid=1, out_valid 2 cycles after accept.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
- Rounding: 0x3F800001 × 0x3F800001:
  - RNE → 0x3F800002 with inexact=1.
  - Repeat with RTZ → 0x3F800002 with inexact=1 (guard 0).
- Overflow: 0x7F000000 × 0x7F000000:
  - RNE → 0x7F800000 with overflow and inexact.
  - RTZ → 0x7F7FFFFF with overflow and inexact.
- Underflow and FTZ:
  - 0x00800000 × 0x3F000000 → 0x00000000 with underflow and inexact.
  - Subnormal input 0x00000001 × 0x40000000 → 0x00000000, flags 0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0.
  - Assert reset at MULT cycle 10: outputs reach reset values immediately, and the next operation after reset gives the correct product.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential FP multiplier.
// Format helpers are sized at elaboration from the exponent/fraction widths.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    localparam int FLG_INVALID = 3;
    localparam int FLG_OVF     = 2;
    localparam int FLG_UDF     = 1;
    localparam int FLG_INX     = 0;

    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] e_ones;
        e_ones = (64'd1 << exp_w) - 64'd1;
        return (e_ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
        logic [63:0] e_max;
        e_max = (64'd1 << exp_w) - 64'd2;
        return (e_max << man_w) | ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_mul_shift_add.sv
// Iterative unsigned P x P multiplier, one shift-add step per clock.
// done is high during the cycle in which the final step is taken.
module fp_mul_shift_add
    import fp_mul_pkg::*;
#(
    parameter int P = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [P-1:0]   op_a,
    input  logic [P-1:0]   op_b,
    output logic           done,
    output logic [2*P-1:0] product
);
    localparam int CW = $clog2(P + 1);

    logic [P-1:0]   mcand;
    logic [2*P-1:0] prod;
    logic [CW-1:0]  cnt;
    logic           running;
    logic [P:0]     sum;

    // Upper half accumulates; multiplier bits drain out of the lower half
    always_comb begin
        sum = {1'b0, prod[2*P-1:P]};
        if (prod[0]) begin
            sum = sum + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= op_a;
            prod    <= {{P{1'b0}}, op_b};
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            prod <= {sum, prod[P-1:1]};
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(P - 1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (cnt == CW'(P - 1));
    assign product = prod;

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle floating-point multiplier with FTZ, RNE/RTZ rounding,
// special-operand bypass and valid/ready handshakes on both sides.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic                 busy
);
    localparam int P    = MAN_W + 1;
    localparam int W    = EXP_W + MAN_W + 1;
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;

    localparam logic signed [EW2-1:0] BIAS_S   = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EXP_TOP  = EW2'(2 ** EXP_W - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [W-1:0]          NAN_V    = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [W-1:0]          MAXF_V   = W'(max_finite(EXP_W, MAN_W));

    state_t state_q, state_d;

    logic [W-1:0]           a_q, b_q;
    logic                   rnd_q;
    logic                   sign_q;
    logic signed [EW2-1:0]  exp_q;
    logic [MAN_W-1:0]       frac_q;
    logic                   guard_q, sticky_q;
    logic [W-1:0]           pend_res;
    logic [3:0]             pend_flg;

    logic                   mul_start, mul_done;
    logic [2*P-1:0]         prod, norm_p;

    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                   inf_zero, any_nan, special, u_sign;
    logic [W-1:0]           spec_res;
    logic [3:0]             spec_flg;
    logic signed [EW2-1:0]  exp_sum;

    logic                   rnd_inc, rnd_carry, inexact;
    logic [MAN_W-1:0]       frac_r;
    logic signed [EW2-1:0]  exp_r;
    logic [W-1:0]           rnd_res;
    logic [3:0]             rnd_flg;

    assign ea = a_q[W-2 -: EXP_W];
    assign eb = b_q[W-2 -: EXP_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // Zero exponent means zero: subnormal inputs are flushed
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == EXP_ONES) && (fa == '0);
    assign b_inf    = (eb == EXP_ONES) && (fb == '0);
    assign a_nan    = (ea == EXP_ONES) && (fa != '0);
    assign b_nan    = (eb == EXP_ONES) && (fb != '0);
    assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
    assign any_nan  = a_nan || b_nan || inf_zero;
    assign special  = any_nan || a_inf || b_inf || a_zero || b_zero;
    assign u_sign   = a_q[W-1] ^ b_q[W-1];
    assign exp_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

    always_comb begin
        spec_res = {u_sign, {(W-1){1'b0}}};
        spec_flg = '0;
        if (any_nan) begin
            spec_res = NAN_V;
            spec_flg[FLG_INVALID] = inf_zero
                                  | (a_nan & ~fa[MAN_W-1])
                                  | (b_nan & ~fb[MAN_W-1]);
        end else if (a_inf || b_inf) begin
            spec_res = {u_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    assign norm_p = prod[2*P-1] ? prod : {prod[2*P-2:0], 1'b0};

    always_comb begin
        rnd_inc = (rnd_q == RND_RNE) & guard_q & (sticky_q | frac_q[0]);
        {rnd_carry, frac_r} = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
        exp_r   = rnd_carry ? exp_q + EXP_ONE : exp_q;
        inexact = guard_q | sticky_q;
        rnd_res = {sign_q, exp_r[EXP_W-1:0], frac_r};
        rnd_flg = '0;
        rnd_flg[FLG_INX] = inexact;
        if (exp_r >= EXP_TOP) begin
            rnd_flg[FLG_OVF] = 1'b1;
            rnd_flg[FLG_INX] = 1'b1;
            if (rnd_q == RND_RTZ) begin
                rnd_res = {sign_q, MAXF_V[W-2:0]};
            end else begin
                rnd_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (exp_r <= EXP_ZERO) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
            rnd_flg[FLG_UDF] = 1'b1;
            rnd_flg[FLG_INX] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        in_ready  = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_UNPACK;
            end
            S_UNPACK: begin
                mul_start = !special;
                state_d   = special ? S_DONE : S_MULT;
            end
            S_MULT: begin
                if (mul_done) state_d = S_NORM;
            end
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                if (out_valid && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results settle into pend_* first; the output register loads one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            rnd_q     <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            frac_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            pend_res  <= '0;
            pend_flg  <= '0;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        rnd_q <= rnd_mode;
                    end
                end
                S_UNPACK: begin
                    sign_q <= u_sign;
                    exp_q  <= exp_sum;
                    if (special) begin
                        pend_res <= spec_res;
                        pend_flg <= spec_flg;
                    end
                end
                S_NORM: begin
                    frac_q   <= norm_p[2*P-2 -: MAN_W];
                    guard_q  <= norm_p[P-1];
                    sticky_q <= |norm_p[P-2:0];
                    exp_q    <= prod[2*P-1] ? exp_q + EXP_ONE : exp_q;
                end
                S_ROUND: begin
                    pend_res <= rnd_res;
                    pend_flg <= rnd_flg;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= pend_res;
                        flags     <= pend_flg;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    fp_mul_shift_add #(
        .P(P)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .op_a    ({1'b1, fa}),
        .op_b    ({1'b1, fb}),
        .done    (mul_done),
        .product (prod)
    );

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq (binary32): directed plan cases plus
// random operands checked against an integer-arithmetic reference model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [35:0] sb[$];

    always #5 clk = ~clk;

    fp_mul_seq #(
        .EXP_W(8),
        .MAN_W(23)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the remainder to half an ulp
    function automatic int ref_mul(input logic [31:0] x, input logic [31:0] y,
                                   input logic rm, output logic [31:0] r,
                                   output logic [3:0] f);
        int ex, ey, e, sh;
        logic s, xnan, ynan, xinf, yinf, xz, yz, inx;
        longint unsigned mx, my, m, keep, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xnan = (ex == 255) && (x[22:0] != 0);
        ynan = (ey == 255) && (y[22:0] != 0);
        xinf = (ex == 255) && (x[22:0] == 0);
        yinf = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        f = 4'h0;
        if (xnan || ynan || (xinf && yz) || (yinf && xz)) begin
            r = 32'h7FC0_0000;
            f[3] = (xinf && yz) || (yinf && xz) || (xnan && !x[22]) || (ynan && !y[22]);
            return 2;
        end
        if (xinf || yinf) begin
            r = {s, 8'hFF, 23'h0};
            return 2;
        end
        if (xz || yz) begin
            r = {s, 31'h0};
            return 2;
        end
        mx = 64'h80_0000 | longint'(x[22:0]);
        my = 64'h80_0000 | longint'(y[22:0]);
        m  = mx * my;
        e  = ex + ey - 127;
        sh = 23;
        if (m >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        keep = m >> sh;
        rem  = m - (keep << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (!rm && ((rem > half) || ((rem == half) && keep[0]))) keep++;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) begin
            f = 4'b0101;
            r = rm ? {s, 8'hFE, 23'h7F_FFFF} : {s, 8'hFF, 23'h0};
        end else if (e <= 0) begin
            f = 4'b0011;
            r = {s, 31'h0};
        end else begin
            f[0] = inx;
            r = {s, 8'(e), keep[22:0]};
        end
        return 28;
    endfunction

    function automatic logic [31:0] rand_op();
        int c;
        logic s;
        logic [7:0] e;
        logic [22:0] fr;
        c  = int'($urandom_range(0, 9));
        s  = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        if (c <= 5)      e = 8'($urandom_range(90, 165));
        else if (c == 6) e = 8'($urandom_range(190, 254));
        else if (c == 7) e = 8'($urandom_range(1, 60));
        else if (c == 8) e = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        else begin
            e  = 8'd127;
            fr = 23'($urandom_range(0, 3));
        end
        return {s, e, fr};
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: result %0h with nothing expected", result);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e[35:4]));
                chk("flags", 64'(flags), 64'(e[3:0]));
            end
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic trm, input logic [31:0] er,
                          input logic [3:0] ef, input int elat, input int hold);
        int n;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        a = ta;
        b = tb_v;
        rnd_mode = trm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        rnd_mode = ~trm;
        sb.push_back({er, ef});
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(elat));
        if (!out_valid) begin
            void'(sb.pop_back());
        end
        held_r = result;
        held_f = flags;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold", {27'h0, out_valid, in_ready, held_f, held_r},
                {27'h0, 1'b1, 1'b0, flags, result});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_handshake", {62'h0, in_ready, out_valid}, 64'd2);
    endtask

    typedef struct {
        logic [31:0] x, y;
        logic        rm;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t dir[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x, y, r;
        logic [3:0]  f;
        logic        rm;
        int          lat;

        dir.push_back('{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 28});
        dir.push_back('{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8, 2});
        dir.push_back('{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0, 2});
        dir.push_back('{32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'h1, 28});
        dir.push_back('{32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'h1, 28});
        dir.push_back('{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'h5, 28});
        dir.push_back('{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'h5, 28});
        dir.push_back('{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'h3, 28});
        dir.push_back('{32'h00000001, 32'h40000000, 1'b0, 32'h00000000, 4'h0, 2});
        dir.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, 2});
        dir.push_back('{32'hFFC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0, 2});

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rnd_mode = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {29'h0, in_ready, out_valid, busy, flags, result},
            {29'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        reset = 1'b0;

        foreach (dir[i]) begin
            run_op(dir[i].x, dir[i].y, dir[i].rm, dir[i].r, dir[i].f,
                   dir[i].lat, (i == 0) ? 5 : 0);
        end

        // Abort an operation mid-multiply, then confirm a clean restart
        a = 32'h40490FDB;
        b = 32'h402DF854;
        rnd_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("reset_async", {29'h0, in_ready, out_valid, busy, flags, result},
            {29'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 28, 0);

        for (int k = 0; k < 60; k++) begin
            x  = rand_op();
            y  = rand_op();
            rm = 1'($urandom_range(0, 1));
            lat = ref_mul(x, y, rm, r, f);
            run_op(x, y, rm, r, f, lat, int'($urandom_range(0, 3)));
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
